// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, issuer FSM states and default ALU latencies shared by the issuer and its timer.
package alu_pkg;
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MUL  = 6'd2;
    localparam logic [5:0] OP_DIV  = 6'd3;
    localparam logic [5:0] OP_FADD = 6'd4;
    localparam logic [5:0] OP_MAX  = 6'd4;

    localparam int DEF_ADD_LAT = 1;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 33;
    localparam int DEF_FP_LAT  = 4;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Invalid opcodes map to zero so their error response leaves WAIT after one cycle.
    function automatic logic [CNT_W-1:0] lat_of(input logic [5:0] op, input int add_lat,
                                                input int mul_lat, input int div_lat, input int fp_lat);
        return (op == OP_ADD || op == OP_SUB) ? CNT_W'(add_lat) :
               (op == OP_MUL)                 ? CNT_W'(mul_lat) :
               (op == OP_DIV)                 ? CNT_W'(div_lat) :
               (op == OP_FADD)                ? CNT_W'(fp_lat)  : '0;
    endfunction
endpackage

// File: rtl/alu_lat_timer.sv
// alu_lat_timer: loadable down-counter preset to LAT(op); expire is high while the count is zero.
module alu_lat_timer
    import alu_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int FP_LAT  = DEF_FP_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       skip,
    input  logic [5:0] op,
    output logic       expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= skip ? '0 : lat_of(op, ADD_LAT, MUL_LAT, DIV_LAT, FP_LAT);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one request at a time to the multicycle ALU and returns its result after LAT(op).
// Define ALU_DIV0_CHECK_EN to answer divide-by-zero locally with an error instead of issuing it.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int FP_LAT  = DEF_FP_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_sr,
    input  logic [31:0] alu_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);
    state_t      state;
    logic        div0;
    logic        bad;
    logic        expire;
    logic        err_pend;
    logic [31:0] err_val;

`ifdef ALU_DIV0_CHECK_EN
    assign div0 = (req_op == OP_DIV) && (req_b == '0);
`else
    assign div0 = 1'b0;
`endif
    assign bad = (req_op > OP_MAX) || div0;

    alu_lat_timer #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .FP_LAT (FP_LAT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (state == S_IDLE && req_valid),
        .skip  (bad),
        .op    (req_op),
        .expire(expire)
    );

    // Rejected requests still pass through WAIT with a zero count, so the error answer is one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sr    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            err_pend  <= 1'b0;
            err_val   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    if (!bad) begin
                        alu_a  <= req_a;
                        alu_b  <= req_b;
                        alu_sr <= req_op;
                    end
                    err_pend  <= bad;
                    err_val   <= div0 ? '1 : '0;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: if (expire) begin
                    rsp_data  <= err_pend ? err_val : alu_y;
                    rsp_err   <= err_pend;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: table vectors, reset/hold sequences and random ops checked against a spec-level model.
module tb_alu_op_issuer;
`ifdef ALU_DIV0_CHECK_EN
    localparam bit DIV0_EN = 1'b1;
`else
    localparam bit DIV0_EN = 1'b0;
`endif
    localparam int LAT_ADD = 1, LAT_MUL = 5, LAT_DIV = 33, LAT_FP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [5:0]  alu_sr;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int checks = 0, failures = 0;
    logic [31:0] pa = '0, pb = '0;
    logic [5:0]  psr = '0;

    always #5 clk = ~clk;

    alu_op_issuer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sr(alu_sr), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    // ALU stand-in: output registered one edge after its inputs; FADD is a stub (xor).
    always @(posedge clk)
        case (alu_sr)
            6'd0: alu_y <= alu_a + alu_b;
            6'd1: alu_y <= alu_a - alu_b;
            6'd2: alu_y <= alu_a * alu_b;
            6'd3: alu_y <= (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            6'd4: alu_y <= alu_a ^ alu_b;
            default: alu_y <= '0;
        endcase

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b;
        int          hold;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // What the host should see for a request, straight from the operation rules.
    task automatic ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] d, output logic e, output int lat);
        if (op > 4) begin
            d = 0; e = 1; lat = 1;
        end else if (DIV0_EN && op == 3 && b == 0) begin
            d = 32'hFFFF_FFFF; e = 1; lat = 1;
        end else begin
            e = 0;
            case (op)
                0: begin d = a + b; lat = LAT_ADD + 1; end
                1: begin d = a - b; lat = LAT_ADD + 1; end
                2: begin d = a * b; lat = LAT_MUL + 1; end
                3: begin d = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = LAT_DIV + 1; end
                default: begin d = a ^ b; lat = LAT_FP + 1; end
            endcase
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input logic [31:0] ed,
                          input logic ee, input int el);
        int n;
        logic issued;
        issued = !(op > 4 || (DIV0_EN && op == 3 && b == 0));
        chk({name, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0; req_a = $urandom; req_b = $urandom;
        if (issued) begin pa = a; pb = b; psr = op; end
        chk({name, "_busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            chk({name, "_alu_a"}, alu_a, pa);
            chk({name, "_alu_b"}, alu_b, pb);
            chk({name, "_alu_sr"}, {26'b0, alu_sr}, {26'b0, psr});
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, n, el);
        chk({name, "_data"}, rsp_data, ed);
        chk({name, "_err"}, {31'b0, rsp_err}, {31'b0, ee});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({name, "_hold_data"}, rsp_data, ed);
            chk({name, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk({name, "_done_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({name, "_done_ready"}, {31'b0, req_ready}, 32'd1);
        chk({name, "_done_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
        chk({name, "_err"}, {31'b0, rsp_err}, 32'd0);
        chk({name, "_data"}, rsp_data, 32'd0);
        chk({name, "_alu_a"}, alu_a, 32'd0);
        chk({name, "_alu_b"}, alu_b, 32'd0);
        chk({name, "_alu_sr"}, {26'b0, alu_sr}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [5:0]  op;
        logic [31:0] a, b;
        int          seen;

        tbl[0] = '{6'd0, 32'd5,   32'd7,  0, 32'd12,         1'b0, 2};
        tbl[1] = '{6'd1, 32'd3,   32'd5,  4, 32'hFFFF_FFFE,  1'b0, 2};
        tbl[2] = '{6'd3, 32'd100, 32'd7,  1, 32'd14,         1'b0, LAT_DIV + 1};
        tbl[3] = '{6'd9, 32'd1,   32'd2,  2, 32'd0,          1'b1, 1};
        tbl[4] = '{6'd2, 32'd6,   32'd7,  0, 32'd42,         1'b0, LAT_MUL + 1};
        tbl[5] = '{6'd4, 32'hF0,  32'h0F, 0, 32'hFF,         1'b0, LAT_FP + 1};
        tbl[6] = DIV0_EN ? '{6'd3, 32'd8, 32'd0, 1, 32'hFFFF_FFFF, 1'b1, 1}
                         : '{6'd3, 32'd8, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, LAT_DIV + 1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold,
                   tbl[i].data, tbl[i].err, tbl[i].lat);

        // Reset in the middle of a divide drops it without a response.
        req_valid = 1; req_op = 6'd3; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1 chk_reset_outputs("midwait_rst");
        @(posedge clk); #1;
        rst = 0;
        pa = '0; pb = '0; psr = '0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("midwait_no_rsp", seen, 0);
        run_op("post_rst_add", 6'd0, 32'd1, 32'd1, 0, 32'd2, 1'b0, 2);

        for (int i = 0; i < 25; i++) begin
            op = 6'($urandom_range(0, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            ref_model(op, a, b, d, e, lat);
            run_op($sformatf("rnd%0d", i), op, a, b, $urandom_range(0, 2), d, e, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
